// File: rtl/int_ram_arb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | int_ram_arb: two-port (external/CPU) req/ack SRAM on a single-port     |
// | array, byte-lane writes, round-robin arbitration. INT_RAM_SCRUB_EN     |
// | enables a post-reset zero scrub. Revision 1.0                          |
// +------------------------------------------------------------------------+
module int_ram_arb #(
    parameter int DW = 16,
    parameter int AW = 6
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_e_req,
    input  logic            i_e_we,
    input  logic [AW-1:0]   i_e_addr,
    input  logic [DW-1:0]   i_e_data,
    input  logic [DW/8-1:0] i_e_sel,
    output logic [DW-1:0]   o_e_data,
    output logic            o_e_ack,
    input  logic            i_c_req,
    input  logic            i_c_we,
    input  logic [AW-1:0]   i_c_addr,
    input  logic [DW-1:0]   i_c_data,
    input  logic [DW/8-1:0] i_c_sel,
    output logic [DW-1:0]   o_c_data,
    output logic            o_c_ack,
    output logic            o_busy
);
    localparam int C_NB    = DW / 8;
    localparam int C_DEPTH = 2 ** AW;

    logic [DW-1:0]   r_mem [0:C_DEPTH-1];
    logic            r_e_ack;
    logic            r_c_ack;
    logic [DW-1:0]   r_e_data;
    logic [DW-1:0]   r_c_data;
    logic            r_last_c;
    logic            w_idle;
    logic            w_e_elig;
    logic            w_c_elig;
    logic            w_e_gnt;
    logic            w_c_gnt;
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [DW-1:0]   w_mem_wdata;
    logic [C_NB-1:0] w_mem_be;

`ifdef INT_RAM_SCRUB_EN
    typedef enum logic [0:0] {
        ST_SCRUB = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          w_scrub;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_SCRUB;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_scrub     = 1'b0;
        if (r_state == ST_SCRUB) begin
            w_scrub   = 1'b1;
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == {AW{1'b1}})
                w_state_nxt = ST_IDLE;
        end
    end

    assign w_idle = (r_state == ST_IDLE);
    assign o_busy = ~w_idle;
`else
    assign w_idle = 1'b1;
    assign o_busy = 1'b0;
`endif

    // A port showing its ack this cycle is ineligible, so a held req is not re-served.
    assign w_e_elig = w_idle & i_e_req & ~r_e_ack;
    assign w_c_elig = w_idle & i_c_req & ~r_c_ack;
    assign w_e_gnt  = w_e_elig & (~w_c_elig | r_last_c);
    assign w_c_gnt  = w_c_elig & (~w_e_elig | ~r_last_c);

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = i_e_addr;
        w_mem_wdata = i_e_data;
        w_mem_be    = i_e_sel;
        if (w_c_gnt) begin
            w_mem_we    = i_c_we;
            w_mem_addr  = i_c_addr;
            w_mem_wdata = i_c_data;
            w_mem_be    = i_c_sel;
        end else if (w_e_gnt) begin
            w_mem_we    = i_e_we;
        end
`ifdef INT_RAM_SCRUB_EN
        if (w_scrub) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_cnt;
            w_mem_wdata = '0;
            w_mem_be    = '1;
        end
`endif
    end

    // Storage is never written while reset is asserted.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_mem_we) begin
            for (int k = 0; k < C_NB; k++) begin
                if (w_mem_be[k])
                    r_mem[w_mem_addr][8*k +: 8] <= w_mem_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_e_ack  <= 1'b0;
            r_c_ack  <= 1'b0;
            r_e_data <= '0;
            r_c_data <= '0;
            r_last_c <= 1'b1;
        end else begin
            r_e_ack <= w_e_gnt;
            r_c_ack <= w_c_gnt;
            if (w_e_gnt)
                r_e_data <= r_mem[i_e_addr];
            if (w_c_gnt)
                r_c_data <= r_mem[i_c_addr];
            if (w_e_gnt)
                r_last_c <= 1'b0;
            else if (w_c_gnt)
                r_last_c <= 1'b1;
        end
    end

    assign o_e_ack  = r_e_ack;
    assign o_c_ack  = r_c_ack;
    assign o_e_data = r_e_data;
    assign o_c_data = r_c_data;

endmodule
`default_nettype wire

// File: tb/tb_int_ram_arb.sv
`default_nettype none
// Bench for int_ram_arb: cycle-level reference model plus directed and random traffic.
module tb_int_ram_arb;
    localparam int DW    = 16;
    localparam int AW    = 6;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          e_req = 1'b0, e_we = 1'b0, c_req = 1'b0, c_we = 1'b0;
    logic [AW-1:0] e_addr = '0, c_addr = '0;
    logic [DW-1:0] e_data = '0, c_data = '0;
    logic [NB-1:0] e_sel = '0, c_sel = '0;
    logic [DW-1:0] o_e_data, o_c_data;
    logic          o_e_ack, o_c_ack, o_busy;

    int_ram_arb #(.DW(DW), .AW(AW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_e_req(e_req), .i_e_we(e_we), .i_e_addr(e_addr), .i_e_data(e_data),
        .i_e_sel(e_sel), .o_e_data(o_e_data), .o_e_ack(o_e_ack),
        .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_data(c_data),
        .i_c_sel(c_sel), .o_c_data(o_c_data), .o_c_ack(o_c_ack),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_valid [DEPTH];
    logic          exp_e_ack, exp_c_ack, exp_busy;
    logic [DW-1:0] exp_e_data, exp_c_data;
    bit            exp_e_known, exp_c_known;
    bit            m_last_c;
    int            scrub_left;
    bit            chk_en = 1'b0;
    bit            m_ge, m_gc;

    task automatic model_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                input logic [NB-1:0] s, output logic [DW-1:0] q, output bit known);
        q     = m_mem[a];
        known = m_valid[a];
        if (we) begin
            for (int k = 0; k < NB; k++)
                if (s[k]) m_mem[a][8*k +: 8] = d[8*k +: 8];
            if (s == '1) m_valid[a] = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            exp_e_ack   = 1'b0;
            exp_c_ack   = 1'b0;
            exp_e_data  = '0;
            exp_c_data  = '0;
            exp_e_known = 1'b1;
            exp_c_known = 1'b1;
            m_last_c    = 1'b1;
`ifdef INT_RAM_SCRUB_EN
            scrub_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]   = '0;
                m_valid[i] = 1'b1;
            end
`else
            scrub_left = 0;
`endif
            chk_en = 1'b1;
        end else if (scrub_left > 0) begin
            scrub_left--;
            exp_e_ack = 1'b0;
            exp_c_ack = 1'b0;
        end else begin
            m_ge = e_req && !exp_e_ack;
            m_gc = c_req && !exp_c_ack;
            if (m_ge && m_gc) begin
                if (m_last_c) m_gc = 1'b0;
                else          m_ge = 1'b0;
            end
            if (m_ge) model_access(e_we, e_addr, e_data, e_sel, exp_e_data, exp_e_known);
            if (m_gc) model_access(c_we, c_addr, c_data, c_sel, exp_c_data, exp_c_known);
            if (m_ge)      m_last_c = 1'b0;
            else if (m_gc) m_last_c = 1'b1;
            exp_e_ack = m_ge;
            exp_c_ack = m_gc;
        end
        exp_busy = (scrub_left > 0);
    end

    int n_e_ack = 0;
    int n_c_ack = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("e_ack", o_e_ack, exp_e_ack);
            check("c_ack", o_c_ack, exp_c_ack);
            check("busy", o_busy, exp_busy);
            if (exp_e_known) check("e_data", o_e_data, exp_e_data);
            if (exp_c_known) check("c_data", o_c_data, exp_c_data);
            if (o_e_ack) n_e_ack++;
            if (o_c_ack) n_c_ack++;
        end
    end

    // ---------------- drivers (called at a falling edge) ----------------
    task automatic e_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NB-1:0] s, input bit hold, output logic [DW-1:0] q, output int ack_cyc);
        int n;
        bit got;
        e_we = we; e_addr = a; e_data = d; e_sel = s; e_req = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            got = o_e_ack;
        end
        check("e_ack_wait", got, 1);
        q = o_e_data;
        ack_cyc = cyc;
        if (hold) @(negedge clk);
        e_req = 1'b0;
    endtask

    task automatic c_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [NB-1:0] s, input bit hold, output logic [DW-1:0] q, output int ack_cyc);
        int n;
        bit got;
        c_we = we; c_addr = a; c_data = d; c_sel = s; c_req = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 30) begin
            @(negedge clk);
            n++;
            got = o_c_ack;
        end
        check("c_ack_wait", got, 1);
        q = o_c_data;
        ack_cyc = cyc;
        if (hold) @(negedge clk);
        c_req = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(output int busy_cycles);
        busy_cycles = 0;
        while (o_busy && busy_cycles < 200) begin
            @(negedge clk);
            busy_cycles++;
        end
        check("busy_bounded", o_busy, 0);
    endtask

    int            ea[4], ca[4];
    logic [DW-1:0] qe, qc;

    initial begin
        int t0, bc, n0, te, tc;
        logic [AW-1:0] ra;

        repeat (2) @(negedge clk);
        check("rst_e_ack", o_e_ack, 0);
        check("rst_c_ack", o_c_ack, 0);
        check("rst_e_data", o_e_data, 0);
        check("rst_c_data", o_c_data, 0);
`ifdef INT_RAM_SCRUB_EN
        check("rst_busy", o_busy, 1);
`else
        check("rst_busy", o_busy, 0);
`endif
        rst = 1'b0;
        wait_idle(bc);
`ifdef INT_RAM_SCRUB_EN
        check("scrub_len", bc, 64);
        c_op(1'b0, 6'h00, '0, '0, 1'b0, qc, tc);
        check("scrub_rd_00", qc, 16'h0000);
        c_op(1'b0, 6'h3F, '0, '0, 1'b0, qc, tc);
        check("scrub_rd_3f", qc, 16'h0000);
`else
        check("scrub_len", bc, 0);
`endif

        // collision right after reset, both ports held with back-to-back reads
        do_reset(2);
        wait_idle(bc);
        t0 = cyc;
        fork
            for (int i = 0; i < 3; i++) e_op(1'b0, AW'(1 + i), '0, '0, 1'b0, qe, ea[i]);
            for (int i = 0; i < 3; i++) c_op(1'b0, AW'(4 + i), '0, '0, 1'b0, qc, ca[i]);
        join
        check("coll_e0", ea[0] - t0, 1);
        check("coll_c0", ca[0] - t0, 2);
        check("coll_e1", ea[1] - t0, 3);
        check("coll_c1", ca[1] - t0, 4);
        check("coll_e2", ea[2] - t0, 5);
        check("coll_c2", ca[2] - t0, 6);

        for (int a = 0; a < DEPTH; a++)
            e_op(1'b1, AW'(a), (a == 5) ? 16'h2222 : DW'($urandom), '1, 1'b0, qe, te);

        // byte-lane masking
        e_op(1'b1, 6'h12, 16'hABCD, 2'b11, 1'b0, qe, te);
        e_op(1'b1, 6'h12, 16'h5500, 2'b10, 1'b0, qe, te);
        check("mask_prewrite", qe, 16'hABCD);
        c_op(1'b0, 6'h12, '0, '0, 1'b0, qc, tc);
        check("mask_read", qc, 16'h55CD);
        e_op(1'b1, 6'h12, 16'h9999, 2'b00, 1'b0, qe, te);
        check("sel0_prewrite", qe, 16'h55CD);

        // held request through ack cycle: exactly one ack
        n0 = n_c_ack;
        c_op(1'b0, 6'h12, '0, '0, 1'b1, qc, tc);
        repeat (3) @(negedge clk);
        check("held_acks", n_c_ack - n0, 1);
        check("held_data", qc, 16'h55CD);

        // back-to-back: 8 acks in 8 cycles, alternating
        fork
            for (int i = 0; i < 4; i++) e_op(1'b1, AW'(32 + i), DW'(16'h1000 + i), '1, 1'b0, qe, ea[i]);
            for (int i = 0; i < 4; i++) c_op(1'b0, AW'(40 + i), '0, '0, 1'b0, qc, ca[i]);
        join
        for (int i = 0; i < 3; i++) begin
            check("b2b_e_step", ea[i+1] - ea[i], 2);
            check("b2b_c_step", ca[i+1] - ca[i], 2);
        end
        check("b2b_interleave", (ca[0] > ea[0]) ? ca[0] - ea[0] : ea[0] - ca[0], 1);

        // randomized traffic, model checks every cycle
        fork
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                ra = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(8, 15)) : AW'($urandom);
                if (ra == 6'h05) ra = 6'h06;
                e_op(1'(($urandom & 1)), ra, DW'($urandom), NB'($urandom), 1'($urandom_range(0, 1)), qe, te);
            end
            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                ra = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(8, 15)) : AW'($urandom);
                if (ra == 6'h05) ra = 6'h07;
                c_op(1'(($urandom & 1)), ra, DW'($urandom), NB'($urandom), 1'($urandom_range(0, 1)), qc, tc);
            end
        join
        repeat (2) @(negedge clk);

        // reset in the grant cycle of an external write
        n0 = n_e_ack;
        e_we = 1'b1; e_addr = 6'h05; e_data = 16'h1111; e_sel = 2'b11; e_req = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        e_req = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_no_ack", n_e_ack - n0, 0);
        wait_idle(bc);
        c_op(1'b0, 6'h05, '0, '0, 1'b0, qc, tc);
`ifdef INT_RAM_SCRUB_EN
        check("rst_wr_read", qc, 16'h0000);
`else
        check("rst_wr_read", qc, 16'h2222);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
